// File: rtl/text_buffer_writer.sv
// Text buffer writer: turns received UART bytes into character-cell RAM
// port-A writes at a tracked cursor, handling CR/LF/BS/FF and clearing the
// row it advances into (or the whole screen after reset and on FF).
module text_buffer_writer #(
    parameter int         ADDR_WIDTH = 12,
    parameter int         COLS       = 80,
    parameter int         ROWS       = 30,
    parameter logic [7:0] FILL_CHAR  = 8'h20,
    localparam int        CW         = $clog2(COLS),
    localparam int        RW         = $clog2(ROWS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  busy,
    output logic                  drop,
    output logic                  wen_a,
    output logic [ADDR_WIDTH-1:0] addr_a,
    output logic [7:0]            din_a,
    output logic [CW-1:0]         cursor_col,
    output logic [RW-1:0]         cursor_row
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CLEAR_ROW = 2'd1,
        CLEAR_ALL = 2'd2
    } state_t;

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    localparam logic [CW-1:0]         LAST_COL     = CW'(COLS - 1);
    localparam logic [RW-1:0]         LAST_ROW     = RW'(ROWS - 1);
    localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE   = ADDR_WIDTH'(COLS);
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW_CNT = ADDR_WIDTH'(COLS - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ALL_CNT = ADDR_WIDTH'(COLS * ROWS - 1);

    state_t                state_q, state_d;
    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;   // row * COLS, kept incrementally
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;             // clear sequence index
    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            din_q, din_d;
    logic                  busy_q, busy_d;
    logic                  drop_q, drop_d;

    logic [RW-1:0]         next_row;
    logic [ADDR_WIDTH-1:0] next_base;
    logic                  printable;

    // Row/base values one row down, wrapping to the top (no scrolling).
    always_comb begin
        if (row_q == LAST_ROW) begin
            next_row  = '0;
            next_base = '0;
        end else begin
            next_row  = row_q + RW'(1);
            next_base = row_base_q + ROW_STRIDE;
        end
    end

    assign printable = (rx_data >= 8'h20) && (rx_data <= 8'h7E);

    // Next-state and registered-output logic for the byte interpreter and clear sequencer.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        cnt_d      = cnt_q;
        wen_d      = 1'b0;
        addr_d     = addr_q;
        din_d      = din_q;
        busy_d     = 1'b0;
        drop_d     = drop_q | (rx_valid & busy_q);

        case (state_q)
            IDLE: begin
                if (rx_valid && !busy_q) begin
                    if (printable) begin
                        wen_d  = 1'b1;
                        addr_d = row_base_q + ADDR_WIDTH'(col_q);
                        din_d  = rx_data;
                        if (col_q == LAST_COL) begin
                            // Character goes out now; the row clear follows next cycle.
                            col_d      = '0;
                            row_d      = next_row;
                            row_base_d = next_base;
                            cnt_d      = '0;
                            busy_d     = 1'b1;
                            state_d    = CLEAR_ROW;
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end else begin
                        case (rx_data)
                            CH_LF: begin
                                // No character to write, so the first clear write goes out immediately.
                                col_d      = '0;
                                row_d      = next_row;
                                row_base_d = next_base;
                                wen_d      = 1'b1;
                                addr_d     = next_base;
                                din_d      = FILL_CHAR;
                                busy_d     = 1'b1;
                                if (COLS == 1) begin
                                    state_d = IDLE;
                                end else begin
                                    cnt_d   = ADDR_WIDTH'(1);
                                    state_d = CLEAR_ROW;
                                end
                            end
                            CH_CR: begin
                                col_d = '0;
                            end
                            CH_BS: begin
                                if (col_q != '0) begin
                                    col_d  = col_q - CW'(1);
                                    wen_d  = 1'b1;
                                    addr_d = row_base_q + ADDR_WIDTH'(col_q - CW'(1));
                                    din_d  = FILL_CHAR;
                                end
                            end
                            CH_FF: begin
                                col_d      = '0;
                                row_d      = '0;
                                row_base_d = '0;
                                cnt_d      = '0;
                                busy_d     = 1'b1;
                                state_d    = CLEAR_ALL;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
            end

            CLEAR_ROW: begin
                wen_d  = 1'b1;
                addr_d = row_base_q + cnt_q;
                din_d  = FILL_CHAR;
                busy_d = 1'b1;
                if (cnt_q == LAST_ROW_CNT) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end

            CLEAR_ALL: begin
                wen_d  = 1'b1;
                addr_d = cnt_q;
                din_d  = FILL_CHAR;
                busy_d = 1'b1;
                if (cnt_q == LAST_ALL_CNT) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset restarts the full-screen clear.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every flop samples pre-edge values.
        if (rst) begin
            state_q    <= CLEAR_ALL;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            cnt_q      <= '0;
            wen_q      <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            busy_q     <= 1'b1;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            cnt_q      <= cnt_d;
            wen_q      <= wen_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            busy_q     <= busy_d;
            drop_q     <= drop_d;
        end
    end

    assign busy       = busy_q;
    assign drop       = drop_q;
    assign wen_a      = wen_q;
    assign addr_a     = addr_q;
    assign din_a      = din_q;
    assign cursor_col = col_q;
    assign cursor_row = row_q;

endmodule

// File: tb/tb_text_buffer_writer.sv
// Directed bench for text_buffer_writer with a write scoreboard: expected
// RAM writes (address, data, cycle) are queued as stimulus is driven and
// popped by a monitor whenever wen_a is seen.
module tb_text_buffer_writer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       busy, drop, wen_a;
    logic [3:0] addr_a;
    logic [7:0] din_a;
    logic [1:0] cursor_col;
    logic [1:0] cursor_row;

    text_buffer_writer #(
        .ADDR_WIDTH(4),
        .COLS      (4),
        .ROWS      (3),
        .FILL_CHAR (8'h20)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .busy      (busy),
        .drop      (drop),
        .wen_a     (wen_a),
        .addr_a    (addr_a),
        .din_a     (din_a),
        .cursor_col(cursor_col),
        .cursor_row(cursor_row)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] din;
        int         cyc;
    } wr_t;

    wr_t exp_q[$];
    int  n_total = 0;
    int  n_pass  = 0;
    int  n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_wr(input int a, input int d, input int c);
        wr_t w;
        w.addr = 4'(a);
        w.din  = 8'(d);
        w.cyc  = c;
        exp_q.push_back(w);
    endtask

    // Monitor: every observed write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (wen_a === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write_addr", 32'(addr_a), 32'hFFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(addr_a), 32'(e.addr));
                check("wr_data", 32'(din_a), 32'(e.din));
                check("wr_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic start_byte(input logic [7:0] b, output int c);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        c        = cyc;
    endtask

    task automatic end_byte();
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(busy), 32'h0);
    endtask

    task automatic check_cursor(input string tag, input int row, input int col);
        check({tag, "_row"}, 32'(cursor_row), 32'(row));
        check({tag, "_col"}, 32'(cursor_col), 32'(col));
    endtask

    task automatic do_reset();
        int c;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_wen", 32'(wen_a), 32'h0);
        check("rst_addr", 32'(addr_a), 32'h0);
        check("rst_din", 32'(din_a), 32'h0);
        check("rst_busy", 32'(busy), 32'h1);
        check("rst_drop", 32'(drop), 32'h0);
        check_cursor("rst_cursor", 0, 0);
        rst = 1'b0;
        c   = cyc;
        for (int i = 0; i < 12; i++) push_wr(i, 8'h20, c + 1 + i);
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            check("clear_all_busy", 32'(busy), (i < 12) ? 32'h1 : 32'h0);
        end
        check_cursor("after_clear_all", 0, 0);
        check("clear_all_drained", 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        int c;

        // 1: reset and full-screen clear
        do_reset();

        // 2: two printable bytes
        start_byte(8'h41, c); push_wr(0, 8'h41, c + 1); end_byte();
        start_byte(8'h42, c); push_wr(1, 8'h42, c + 1); end_byte();
        check_cursor("after_AB", 0, 2);
        check("after_AB_busy", 32'(busy), 32'h0);

        // ignored bytes leave everything alone
        start_byte(8'h7F, c); end_byte();
        start_byte(8'h01, c); end_byte();
        start_byte(8'hC3, c); end_byte();
        check_cursor("after_ignored", 0, 2);
        start_byte(8'h0D, c); end_byte();
        check_cursor("after_CR", 0, 0);

        // 3: fill row 0, wrap into row 1 and clear it
        start_byte(8'h57, c); push_wr(0, 8'h57, c + 1); end_byte();
        start_byte(8'h58, c); push_wr(1, 8'h58, c + 1); end_byte();
        start_byte(8'h59, c); push_wr(2, 8'h59, c + 1); end_byte();
        start_byte(8'h5A, c); push_wr(3, 8'h5A, c + 1);
        for (int k = 0; k < 4; k++) push_wr(4 + k, 8'h20, c + 2 + k);
        end_byte();
        check("wrap_busy_first", 32'(busy), 32'h1);
        check_cursor("after_WXYZ", 1, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("wrap_busy", 32'(busy), (i < 4) ? 32'h1 : 32'h0);
        end
        check("wrap_drained", 32'(exp_q.size()), 32'h0);

        // 4: LF into row 2, one char, then LF wraps to row 0
        start_byte(8'h0A, c);
        for (int k = 0; k < 4; k++) push_wr(8 + k, 8'h20, c + 1 + k);
        end_byte();
        wait_idle();
        check_cursor("after_LF1", 2, 0);
        start_byte(8'h51, c); push_wr(8, 8'h51, c + 1); end_byte();
        check_cursor("row2_col1", 2, 1);
        start_byte(8'h0A, c);
        for (int k = 0; k < 4; k++) push_wr(k, 8'h20, c + 1 + k);
        end_byte();
        check("lf_busy_first", 32'(busy), 32'h1);
        check_cursor("after_LF_wrap", 0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("lf_busy", 32'(busy), (i < 3) ? 32'h1 : 32'h0);
        end
        check("lf_drained", 32'(exp_q.size()), 32'h0);

        // 5: backspace down to column 0 and one past it
        start_byte(8'h50, c); push_wr(0, 8'h50, c + 1); end_byte();
        start_byte(8'h52, c); push_wr(1, 8'h52, c + 1); end_byte();
        start_byte(8'h08, c); push_wr(1, 8'h20, c + 1); end_byte();
        check_cursor("after_BS1", 0, 1);
        start_byte(8'h08, c); push_wr(0, 8'h20, c + 1); end_byte();
        check_cursor("after_BS2", 0, 0);
        start_byte(8'h08, c); end_byte();
        @(negedge clk);
        check_cursor("after_BS3", 0, 0);

        // printable range boundaries
        start_byte(8'h7E, c); push_wr(0, 8'h7E, c + 1); end_byte();
        start_byte(8'h20, c); push_wr(1, 8'h20, c + 1); end_byte();
        check_cursor("after_bounds", 0, 2);

        // 6: FF with a byte arriving while busy
        start_byte(8'h0C, c);
        for (int k = 0; k < 12; k++) push_wr(k, 8'h20, c + 2 + k);
        end_byte();
        check("ff_busy", 32'(busy), 32'h1);
        check_cursor("after_FF", 0, 0);
        start_byte(8'h4B, c); end_byte();
        check("drop_set", 32'(drop), 32'h1);
        wait_idle();
        check("ff_drained", 32'(exp_q.size()), 32'h0);
        check("drop_sticky", 32'(drop), 32'h1);
        start_byte(8'h4D, c); push_wr(0, 8'h4D, c + 1); end_byte();
        check("drop_still", 32'(drop), 32'h1);
        check_cursor("after_M", 0, 1);

        // reset clears drop and reruns the full clear
        do_reset();

        @(negedge clk);
        check("final_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/text_buffer_writer.md
Name: text_buffer_writer

Overview:
- Upstream stage of the character-cell text buffer RAM.
- Consumes bytes from the UART receiver and turns them into RAM port-A writes (wen_a/addr_a/din_a) at a tracked cursor position.
- Interprets a small control-character set: CR, LF, BS, FF.
- Clears the row it advances into, and clears the whole screen after reset and on FF.
- The VGA side reads the same RAM on port B.

Parameters:
- ADDR_WIDTH, 12: RAM address width. Requires COLS*ROWS <= 2**ADDR_WIDTH.
- COLS, 80: characters per row.
- ROWS, 30: rows per screen.
- FILL_CHAR, 8'h20: byte written when clearing.
- Derived widths: CW = $clog2(COLS), RW = $clog2(ROWS).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
- busy  out  1  high while clearing; bytes presented while high are discarded.
- drop  out  1  sticky flag: a byte arrived while busy. Cleared only by rst.
- wen_a  out  1  RAM write enable.
- addr_a  out  ADDR_WIDTH  RAM write address, equal to row*COLS+col.
- din_a  out  8  RAM write data.
- cursor_col  out  CW  current column, for cursor rendering.
- cursor_row  out  RW  current row.

Behaviour:
- All outputs are registered.
- While rst is high: wen_a=0, addr_a=0, din_a=0, drop=0, cursor=(0,0), busy=1, state forced to CLEAR_ALL with clear counter 0.
- States: IDLE, CLEAR_ROW, CLEAR_ALL.
- IDLE, rx_valid=1 at edge of cycle N: the byte is accepted. Any resulting write is presented in cycle N+1 with wen_a=1 for exactly one cycle.
- Printable byte (0x20-0x7E):
  - Write the byte at the current cursor position; col increments.
  - If col was COLS-1: col=0, row=(row+1) mod ROWS, enter CLEAR_ROW.
- LF (0x0A): no character write. col=0, row=(row+1) mod ROWS, enter CLEAR_ROW.
- CR (0x0D): col=0; no write; stay in IDLE.
- BS (0x08):
  - If col>0: col decrements, then FILL_CHAR is written at the new position.
  - If col=0: no-op (no write, no row change).
- FF (0x0C): no write; cursor=(0,0); enter CLEAR_ALL.
- All other bytes (controls, 0x7F-0xFF) are ignored: no write, no state change.
- CLEAR_ROW:
  - Writes FILL_CHAR to the new row, k=0..COLS-1, one write per cycle.
  - Addresses are row*COLS+k.
  - Returns to IDLE after the last write.
- CLEAR_ALL:
  - Writes FILL_CHAR to addresses 0..COLS*ROWS-1, one per cycle.
  - Returns to IDLE after the last write.
- busy timing:
  - Goes high in cycle N+1 after the byte that triggered clearing.
  - Stays high through the final clear write.
  - Falls in the cycle after the final clear write.
  - Row-advance by printable byte at cycle N: character write at N+1; clear writes at N+2..N+1+COLS; busy high N+1..N+1+COLS.
  - Row-advance by LF at cycle N: clear writes at N+1..N+COLS; busy high N+1..N+COLS.
- Cursor outputs update in the same cycle as the associated write (N+1).
- rx_valid with busy=1: the byte is discarded, drop is set, and the clear sequence is unaffected.
- Row wrap: advancing from row ROWS-1 goes to row 0 and clears row 0. There is no scrolling.
- Address arithmetic:
  - Maintain a row_base register that increments by COLS per row advance and wraps to 0 after the last row; no multiplier.
  - addr_a = row_base + col (or row_base + k during CLEAR_ROW), zero-extended to ADDR_WIDTH.
- rst mid-clear or mid-write: aborts immediately, then restarts CLEAR_ALL from address 0.

Test Plan:
Bench parameters: COLS=4, ROWS=3, ADDR_WIDTH=4.
1. Pulse rst, then release -> 12 consecutive writes of 0x20 to addr 0..11, one per cycle. busy=1 through the last write, then 0. Cursor=(0,0).
2. After idle, send 'A' then 'B' -> addr 0 din 0x41, then addr 1 din 0x42, each 1 cycle after its rx_valid. cursor_col=2, no other writes.
3. Send "WXYZ" from (0,0) -> 'Z' written at addr 3. Then writes of 0x20 to addr 4..7 in the following 4 cycles. busy high for 5 cycles. Cursor ends at (1,0).
4. At row 2, col 1, send LF -> 0x20 written to addr 0..3 on cycles N+1..N+4; busy high N+1..N+4; cursor=(0,0). Nothing written to addr 9.
5. At (0,2), send BS -> addr 1 din 0x20, cursor_col=1. Send BS twice more -> one write to addr 0, then no write on the second; col stays 0.
6. Send FF, then a byte on the next busy cycle -> 12 clear writes to addr 0..11; the byte is never written; drop=1 and stays 1 until rst; cursor=(0,0).
